writeback_stage_mw: RTL and testbench

- Parametrised successor to the single-register writeback stage: a BUF_DEPTH-entry in-order writeback queue between the memory stage and the register-file write port.
- Generalises partial-word (LWL/LWR-style) merging to any byte-multiple data width.
- Adds valid/ready handshakes on both sides, a pipeline flush, and a pending-write lookup port so decode can detect hazards against queued writes.

---
 rtl/writeback_stage_mw_pkg.sv | 92 +++++++++
 rtl/writeback_stage_mw_merge.sv | 24 ++
 rtl/writeback_stage_mw.sv | 134 +++++++++++++
 tb/tb_writeback_stage_mw.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_mw_pkg.sv
// Shared types and merge helpers for the multi-entry writeback queue.
// Widths are sized for the largest supported configuration; instances truncate to their own widths.
package writeback_stage_mw_pkg;

    localparam int MAX_DATA_W = 512;
    localparam int MAX_NB     = MAX_DATA_W / 8;
    localparam int MAX_OFF_W  = $clog2(MAX_NB);
    localparam int MAX_RA_W   = 8;

    localparam int OP_LMERGE = 2;
    localparam int OP_RMERGE = 3;
    localparam logic [4:0] OP_FULL_WRITE = 5'b00000;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_FULL,
        WB_LEFT,
        WB_RIGHT
    } wb_kind_e;

    typedef struct packed {
        logic [4:0]            op;
        logic [MAX_RA_W-1:0]   dest;
        logic [MAX_DATA_W-1:0] value;
        logic [MAX_OFF_W-1:0]  off;
        logic [31:0]           pc;
    } wb_entry_t;

    // Only the exact single-bit merge encodings merge; both bits set, or any stray bit, means no write.
    function automatic wb_kind_e wb_kind(input logic [4:0] op);
        wb_kind_e kind;
        if (op == OP_FULL_WRITE) begin
            kind = WB_FULL;
        end else if (op == (5'b00001 << OP_LMERGE)) begin
            kind = WB_LEFT;
        end else if (op == (5'b00001 << OP_RMERGE)) begin
            kind = WB_RIGHT;
        end else begin
            kind = WB_NONE;
        end
        return kind;
    endfunction

    function automatic logic [MAX_NB-1:0] merge_wen(
        input logic [4:0]           op,
        input logic [MAX_OFF_W-1:0] off,
        input logic [MAX_RA_W-1:0]  dest,
        input int                   nb
    );
        logic [MAX_NB-1:0] wen;
        wb_kind_e          kind;
        int                k;
        wen  = '0;
        kind = wb_kind(op);
        k    = int'(off);
        for (int i = 0; i < MAX_NB; i++) begin
            if (i < nb) begin
                case (kind)
                    WB_FULL:  wen[i] = 1'b1;
                    WB_LEFT:  wen[i] = (i >= nb - 1 - k);
                    WB_RIGHT: wen[i] = (i < nb - k);
                    default:  wen[i] = 1'b0;
                endcase
            end
        end
        if (dest == '0) begin
            wen = '0;
        end
        return wen;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] merge_wdata(
        input logic [4:0]            op,
        input logic [MAX_OFF_W-1:0]  off,
        input logic [MAX_DATA_W-1:0] value,
        input int                    nb
    );
        logic [MAX_DATA_W-1:0] data;
        int                    k;
        int                    sh;
        k  = int'(off);
        sh = (nb - 1 - k < 0) ? 0 : nb - 1 - k;
        case (wb_kind(op))
            WB_FULL:  data = value;
            WB_LEFT:  data = value << (8 * sh);
            WB_RIGHT: data = value >> (8 * k);
            default:  data = '0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/writeback_stage_mw_merge.sv
// Combinational byte-lane merge for the queue head entry.
// All outputs are zero when the head is not valid.
module wb_merge_unit
    import writeback_stage_mw_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic                  valid_i,
    input  logic [4:0]            op_i,
    input  logic [MAX_RA_W-1:0]   dest_i,
    input  logic [MAX_DATA_W-1:0] value_i,
    input  logic [MAX_OFF_W-1:0]  off_i,
    output logic [DATA_W/8-1:0]   wen_o,
    output logic [RA_W-1:0]       waddr_o,
    output logic [DATA_W-1:0]     wdata_o
);
    localparam int NB = DATA_W / 8;

    assign wen_o   = valid_i ? NB'(merge_wen(op_i, off_i, dest_i, NB)) : '0;
    assign waddr_o = valid_i ? RA_W'(dest_i) : '0;
    assign wdata_o = valid_i ? DATA_W'(merge_wdata(op_i, off_i, value_i, NB)) : '0;

endmodule

// File: rtl/writeback_stage_mw.sv
// In-order writeback queue between the memory stage and the register-file write port,
// with flush and a pending-write lookup for decode hazard detection.
module writeback_stage_mw
    import writeback_stage_mw_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int RA_W      = 5,
    parameter  int BUF_DEPTH = 2,
    localparam int NB        = DATA_W / 8,
    localparam int OFF_W     = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [RA_W-1:0]   in_dest,
    input  logic [DATA_W-1:0] in_value,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [31:0]       in_pc,
    input  logic              rf_ready,
    output logic [NB-1:0]     rf_wen,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_valid,
    output logic [4:0]        wb_op,
    output logic [31:0]       wb_pc,
    input  logic [RA_W-1:0]   q_addr,
    output logic              q_hit,
    output logic [NB-1:0]     q_wen
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    wb_entry_t        mem_q [BUF_DEPTH];
    wb_entry_t        in_entry;
    wb_entry_t        head_entry;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // in_ready depends only on registered count so rf_ready never reaches it combinationally.
    assign in_ready   = (count_q != FULL_CNT);
    assign wb_valid   = (count_q != '0) && !flush;
    assign push       = in_valid && in_ready && !flush;
    assign pop        = wb_valid && rf_ready;
    assign head_entry = mem_q[head_q];

    always_comb begin
        in_entry       = '0;
        in_entry.op    = in_op;
        in_entry.dest  = MAX_RA_W'(in_dest);
        in_entry.value = MAX_DATA_W'(in_value);
        in_entry.off   = MAX_OFF_W'(in_off);
        in_entry.pc    = in_pc;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is never reset; validity comes solely from count/head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    wb_merge_unit #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_merge (
        .valid_i (wb_valid),
        .op_i    (head_entry.op),
        .dest_i  (head_entry.dest),
        .value_i (head_entry.value),
        .off_i   (head_entry.off),
        .wen_o   (rf_wen),
        .waddr_o (rf_waddr),
        .wdata_o (rf_wdata)
    );

    assign wb_op = wb_valid ? head_entry.op : '0;
    assign wb_pc = wb_valid ? head_entry.pc : '0;

    // An entry is live when its distance from head (mod depth) is below count.
    always_comb begin
        q_wen = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - head_q} < count_q) &&
                (mem_q[i].dest == MAX_RA_W'(q_addr))) begin
                q_wen = q_wen | NB'(merge_wen(mem_q[i].op, mem_q[i].off, mem_q[i].dest, NB));
            end
        end
    end

    assign q_hit = |q_wen;

endmodule

// File: tb/tb_writeback_stage_mw.sv
// Bench for writeback_stage_mw: directed scenarios plus random traffic against a queue-based model,
// and a 64-bit instance for wide merges and asynchronous reset.
module tb_writeback_stage_mw;
    localparam int DATA_W = 32;
    localparam int NB     = 4;
    localparam int OFF_W  = 2;
    localparam int RA_W   = 5;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush, in_valid, in_ready, rf_ready, wb_valid, q_hit;
    logic [4:0]        in_op, wb_op;
    logic [RA_W-1:0]   in_dest, rf_waddr, q_addr;
    logic [DATA_W-1:0] in_value, rf_wdata;
    logic [OFF_W-1:0]  in_off;
    logic [31:0]       in_pc, wb_pc;
    logic [NB-1:0]     rf_wen, q_wen;

    logic        reset64, flush64, in_valid64, in_ready64, rf_ready64, wb_valid64, q_hit64;
    logic [4:0]  in_op64, wb_op64;
    logic [4:0]  in_dest64, rf_waddr64, q_addr64;
    logic [63:0] in_value64, rf_wdata64;
    logic [2:0]  in_off64;
    logic [31:0] in_pc64, wb_pc64;
    logic [7:0]  rf_wen64, q_wen64;

    writeback_stage_mw #(.DATA_W(DATA_W), .RA_W(RA_W), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dest(in_dest), .in_value(in_value), .in_off(in_off), .in_pc(in_pc),
        .rf_ready(rf_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_valid(wb_valid), .wb_op(wb_op), .wb_pc(wb_pc),
        .q_addr(q_addr), .q_hit(q_hit), .q_wen(q_wen)
    );

    writeback_stage_mw #(.DATA_W(64), .RA_W(5), .BUF_DEPTH(2)) dut64 (
        .clk(clk), .reset(reset64), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_op(in_op64), .in_dest(in_dest64), .in_value(in_value64), .in_off(in_off64), .in_pc(in_pc64),
        .rf_ready(rf_ready64), .rf_wen(rf_wen64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64),
        .wb_valid(wb_valid64), .wb_op(wb_op64), .wb_pc(wb_pc64),
        .q_addr(q_addr64), .q_hit(q_hit64), .q_wen(q_wen64)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        int          dest;
        logic [31:0] value;
        int          off;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] seen[$];
    bit          pushed_last;

    function automatic logic [NB-1:0] exp_wen(input ent_t e);
        int m;
        if (e.dest == 0) return '0;
        case (e.op)
            5'd0:    m = (1 << NB) - 1;
            5'd4:    m = ((1 << (e.off + 1)) - 1) << (NB - 1 - e.off);
            5'd8:    m = (1 << (NB - e.off)) - 1;
            default: m = 0;
        endcase
        return m[NB-1:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input ent_t e);
        case (e.op)
            5'd0:    return e.value;
            5'd4:    return e.value << (8 * (NB - 1 - e.off));
            5'd8:    return e.value >> (8 * e.off);
            default: return '0;
        endcase
    endfunction

    task automatic check_outputs();
        bit            hv;
        ent_t          h;
        logic [NB-1:0] ew;
        logic [NB-1:0] qw;
        hv = (mq.size() != 0) && !flush;
        check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        check("wb_valid", 64'(wb_valid), 64'(hv));
        if (hv) begin
            h  = mq[0];
            ew = exp_wen(h);
            check("rf_wen", 64'(rf_wen), 64'(ew));
            check("rf_waddr", 64'(rf_waddr), 64'(h.dest));
            check("wb_op", 64'(wb_op), 64'(h.op));
            check("wb_pc", 64'(wb_pc), 64'(h.pc));
            if (ew != 0) check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata(h)));
        end else begin
            check("rf_wen_idle", 64'(rf_wen), 64'(0));
            check("rf_wdata_idle", 64'(rf_wdata), 64'(0));
            check("wb_pc_idle", 64'(wb_pc), 64'(0));
        end
        if (wb_valid && rf_ready) seen.push_back(rf_wdata);
        qw = '0;
        foreach (mq[i]) begin
            if (q_addr != 0 && mq[i].dest == int'(q_addr)) qw = qw | exp_wen(mq[i]);
        end
        check("q_wen", 64'(q_wen), 64'(qw));
        check("q_hit", 64'(q_hit), 64'(qw != 0));
    endtask

    task automatic update_model();
        bit can_push;
        bit do_pop;
        pushed_last = 1'b0;
        if (flush) begin
            mq.delete();
            return;
        end
        can_push = in_valid && (mq.size() != DEPTH);
        do_pop   = (mq.size() != 0) && rf_ready;
        if (do_pop) void'(mq.pop_front());
        if (can_push) begin
            mq.push_back('{in_op, int'(in_dest), in_value, int'(in_off), in_pc});
            pushed_last = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] op, input int dest, input logic [31:0] val, input int off);
        in_valid = 1'b1;
        in_op    = op;
        in_dest  = RA_W'(dest);
        in_value = val;
        in_off   = OFF_W'(off);
        in_pc    = $urandom;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit accepted;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_dest = '0; in_value = '0;
        in_off = '0; in_pc = '0; rf_ready = 1'b0; q_addr = '0;
        reset64 = 1'b1; flush64 = 1'b0; in_valid64 = 1'b0; in_op64 = '0; in_dest64 = '0;
        in_value64 = '0; in_off64 = '0; in_pc64 = '0; rf_ready64 = 1'b0; q_addr64 = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_rf_wen", 64'(rf_wen), 64'(0));
        check("rst_q_hit", 64'(q_hit), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        reset64 = 1'b0;

        // Full write, then drained the following cycle
        rf_ready = 1'b1;
        push(5'd0, 3, 32'h12345678, 0);
        check("t1_wen", 64'(rf_wen), 64'hF);
        check("t1_waddr", 64'(rf_waddr), 64'd3);
        check("t1_wdata", 64'(rf_wdata), 64'h12345678);
        cycle();
        check("t1_empty", 64'(wb_valid), 64'(0));

        // Merge variants
        push(5'd4, 4, 32'hAABBCCDD, 1);
        check("lm1_wen", 64'(rf_wen), 64'hC);
        check("lm1_wdata", 64'(rf_wdata), 64'hCCDD0000);
        cycle();
        push(5'd8, 4, 32'hAABBCCDD, 2);
        check("rm2_wen", 64'(rf_wen), 64'h3);
        check("rm2_wdata", 64'(rf_wdata), 64'h0000AABB);
        cycle();
        push(5'd8, 4, 32'hAABBCCDD, 0);
        check("rm0_wen", 64'(rf_wen), 64'hF);
        cycle();

        // Backpressure: third entry held until space frees, order preserved
        rf_ready = 1'b0;
        seen.delete();
        push(5'd0, 6, 32'h11111111, 0);
        push(5'd0, 7, 32'h22222222, 0);
        check("bp_full", 64'(in_ready), 64'(0));
        in_valid = 1'b1; in_op = 5'd0; in_dest = 5'd8; in_value = 32'h33333333; in_off = '0;
        cycle();
        check("bp_held", 64'(in_ready), 64'(0));
        rf_ready = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 10 && !accepted; n++) begin
            cycle();
            accepted = pushed_last;
        end
        check("bp_accept", 64'(accepted), 64'(1));
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bp_count", 64'(seen.size()), 64'(3));
        if (seen.size() == 3) begin
            check("bp_ord0", 64'(seen[0]), 64'h11111111);
            check("bp_ord1", 64'(seen[1]), 64'h22222222);
            check("bp_ord2", 64'(seen[2]), 64'h33333333);
        end

        // Hazard lookup
        rf_ready = 1'b0;
        push(5'd4, 5, 32'hDEADBEEF, 0);
        push(5'd0, 5, 32'hCAFEF00D, 0);
        q_addr = 5'd5; #1;
        check("lk_hit", 64'(q_hit), 64'(1));
        check("lk_wen", 64'(q_wen), 64'hF);
        q_addr = 5'd0; #1;
        check("lk_zero", 64'(q_hit), 64'(0));
        rf_ready = 1'b1;
        repeat (2) cycle();
        rf_ready = 1'b0;
        push(5'd0, 0, 32'h55555555, 0);
        check("lk_r0_wen", 64'(rf_wen), 64'(0));
        check("lk_r0_hit", 64'(q_hit), 64'(0));
        rf_ready = 1'b1;
        cycle();

        // Flush on a full queue with simultaneous push and pop request
        rf_ready = 1'b0;
        push(5'd0, 9, 32'h99999999, 0);
        push(5'd0, 10, 32'hAAAA5555, 0);
        in_valid = 1'b1; in_dest = 5'd11; flush = 1'b1; rf_ready = 1'b1; #1;
        check("fl_valid", 64'(wb_valid), 64'(0));
        check("fl_wen", 64'(rf_wen), 64'(0));
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_ready", 64'(in_ready), 64'(1));
        check("fl_empty", 64'(wb_valid), 64'(0));
        cycle();

        // Random traffic against the model
        repeat (600) begin
            in_valid = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 5))
                0: in_op = 5'd0;
                1: in_op = 5'd4;
                2: in_op = 5'd8;
                3: in_op = 5'd12;
                4: in_op = 5'($urandom);
                default: in_op = 5'd0;
            endcase
            in_dest  = RA_W'($urandom_range(0, 7));
            in_value = $urandom;
            in_off   = OFF_W'($urandom);
            in_pc    = $urandom;
            rf_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            q_addr   = RA_W'($urandom_range(0, 7));
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
        repeat (3) cycle();

        // 64-bit left merge, then asynchronous reset with an entry pending
        in_valid64 = 1'b1; in_op64 = 5'd4; in_dest64 = 5'd7;
        in_value64 = 64'h0102030405060708; in_off64 = 3'd2; q_addr64 = 5'd7;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        check("w64_valid", 64'(wb_valid64), 64'(1));
        check("w64_wen", 64'(rf_wen64), 64'hE0);
        check("w64_wdata", rf_wdata64, 64'h0607080000000000);
        check("w64_qhit", 64'(q_hit64), 64'(1));
        #2;
        reset64 = 1'b1; #1;
        check("ar_valid", 64'(wb_valid64), 64'(0));
        check("ar_wen", 64'(rf_wen64), 64'(0));
        check("ar_wdata", rf_wdata64, 64'(0));
        check("ar_ready", 64'(in_ready64), 64'(1));
        check("ar_qhit", 64'(q_hit64), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
